spi_design: RTL and testbench
=============================

Name: spi_design

Overview:
- Self-contained SPI loopback block with a 12-bit SPI master and an SPI slave wired back-to-back inside one module.
- A request on newd/din makes the master shift din out serially (LSB first) on an internally generated sclk.
- The slave deserialises the bits and presents the word on dout, with a done pulse.
- Used as a transfer-integrity unit: after every completed transfer, dout must equal the din that was sent.

Parameters:
- DIV, 10, number of clk cycles per sclk half-period (sclk period = 2*DIV clk cycles); must be at least 2.
- Data width is fixed at 12 bits; it is not a parameter.

Ports:
- clk  input  1  single system clock; all flops are on its rising edge.
- rst  input  1  synchronous reset, active-low; sampled on clk rising edge.
- newd  input  1  start request; sampled only on sclk rising ticks while the master is idle.
- din  input  12  word to transmit; captured when the start request is accepted.
- dout  output  12  last word received by the slave.
- done  output  1  high for one sclk period when dout has just been updated.

Behaviour:
- Hierarchy: the master is a submodule instance named s1 and must contain a register named sclk (the serial clock), so benches can probe s1.sclk. The slave is a separate submodule instance.
- Only clk is used as a clock. sclk is a register, not a clock net; all logic advances on clk using sclk tick enables.
- Reset (rst=0 at a clk edge) forces: sclk=0, divider count=0, cs=1, mosi=0, master IDLE, bit counters=0, slave shift register=0, dout=0, done=0.
- Reset applied mid-transfer aborts the transfer immediately; no done pulse is produced.
- Divider:
  - count runs 0..DIV-1; at count==DIV-1, sclk toggles and count wraps to 0.
  - rise_tick = (count==DIV-1 && sclk==0).
  - fall_tick = (count==DIV-1 && sclk==1).
- Master FSM, IDLE state:
  - cs=1, mosi=0.
  - On rise_tick with newd=1: latch din, drive cs=0 and mosi=din[0], set bitcnt=1, go to SEND.
- Master FSM, SEND state, on each rise_tick:
  - If bitcnt<12: mosi=latched[bitcnt], bitcnt++.
  - Else (bitcnt==12): cs=1, mosi=0, go to IDLE.
- Master rules:
  - newd and din are ignored while in SEND.
  - If newd is still high on the first rise_tick back in IDLE, a new transfer starts.
- Slave:
  - On fall_tick with cs=0: shreg={mosi, shreg[11:1]} (LSB-first reassembly), rcnt++.
  - When the 12th bit is sampled: dout takes the completed word in the same clk edge, done=1, rcnt=0.
  - done clears at the next fall_tick, so it is high for exactly one sclk period (2*DIV clk cycles).
  - While cs=1, the slave holds rcnt=0 and does not shift.
- Latency:
  - The accepting rise_tick is R0. Bit k is driven at rise_tick Rk and sampled at the following fall_tick Fk.
  - done rises at F11, i.e. 11.5 sclk periods after R0 (230 clk cycles with DIV=10).
  - Minimum spacing between consecutive accepted requests is 13 sclk periods.
- Bit order: LSB first. dout must equal the accepted din bit-exactly, including 12'h000 and 12'hFFF.
- dout holds its value between transfers; done never rises without a completed 12-bit transfer.

Test Plan:
- Reset: hold rst=0 for 5 clk cycles, then rst=1 -> dout=0, done=0, s1.sclk=0, cs=1; s1.sclk toggles every 10 clk cycles afterwards.
- Single transfer: din=12'hA5C, newd=1 until the first s1.sclk rise, then newd=0 -> done rises 230 clk cycles after the accepting edge; dout=12'hA5C; done high for 20 clk cycles.
- Corner data: din=12'h000, then 12'hFFF, then 12'h001 -> dout matches each value exactly (checks LSB-first ordering and the extremes).
- Back-to-back: 5 random 12-bit words, each issued after the previous done -> each dout equals its din; exactly 5 done pulses.
- Busy/request handling: change din and pulse newd mid-transfer -> the in-flight word is unaffected. Holding newd high continuously -> transfers repeat with 13-sclk spacing.
- Mid-transfer reset: assert rst=0 after bit 5 -> no done pulse, dout=0, cs=1; the next transfer (din=12'h3C3) completes correctly.

Source files
------------

// File: rtl/spi_design.sv
// SPI loopback block: a 12-bit SPI master (instance s1) and an SPI slave
// (instance s2) wired back-to-back. Every completed transfer leaves the
// transmitted word on dout with a one-sclk-period done pulse.
// The whole block runs on clk; sclk is a divided register, never a clock net.

// ---------------------------------------------------------------------------
// spi_master: sclk divider plus the IDLE/SEND shift FSM (LSB first).
// ---------------------------------------------------------------------------
module spi_master #(
  parameter int DIV = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        newd,
  input  logic [11:0] din,
  output logic        cs,
  output logic        mosi,
  output logic        fall_tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Debug-visible state: state, bitcnt, count and sclk are plain registers
  // so checkers can bind to them directly.
  state_t        state;
  logic [CW-1:0] count;
  logic          sclk;
  logic [3:0]    bitcnt;
  logic [11:0]   latched;
  logic          rise_tick;

  // rise_tick / fall_tick mark the clk edge on which sclk goes high / low.
  assign rise_tick = (count == LAST) && !sclk;
  assign fall_tick = (count == LAST) &&  sclk;

  // Divider: count 0..DIV-1, toggle sclk and wrap on the last count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      sclk  <= 1'b0;
    end else if (count == LAST) begin
      count <= '0;
      sclk  <= ~sclk;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Request handshake: newd is a level request, sampled only on a rise_tick
  // while the FSM is IDLE; acceptance latches din on that same edge (cs
  // falls). While SEND is active newd/din are ignored; a newd still high at
  // the first IDLE rise_tick starts the next transfer.
  // FSM: drive bit k of the latched word on rise_tick Rk, release cs at R12.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cs      <= 1'b1;
      mosi    <= 1'b0;
      bitcnt  <= 4'd0;
      latched <= 12'd0;
    end else if (rise_tick) begin
      case (state)
        IDLE: begin
          cs   <= 1'b1;
          mosi <= 1'b0;
          if (newd) begin
            latched <= din;
            cs      <= 1'b0;
            mosi    <= din[0];
            bitcnt  <= 4'd1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (bitcnt < 4'd12) begin
            mosi   <= latched[bitcnt];
            bitcnt <= bitcnt + 4'd1;
          end else begin
            cs     <= 1'b1;
            mosi   <= 1'b0;
            bitcnt <= 4'd0;
            state  <= IDLE;
          end
        end
        default: begin
          cs    <= 1'b1;
          mosi  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// ---------------------------------------------------------------------------
// spi_slave: samples mosi on fall_tick while cs is low and rebuilds the word.
// ---------------------------------------------------------------------------
module spi_slave (
  input  logic        clk,
  input  logic        rst,
  input  logic        fall_tick,
  input  logic        cs,
  input  logic        mosi,
  output logic [11:0] dout,
  output logic        done
);

  logic [11:0] shreg;
  logic [3:0]  rcnt;

  // Shift in LSB first; on the 12th bit publish the word and raise done,
  // which then lasts until the next fall_tick (one sclk period).
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg <= 12'd0;
      rcnt  <= 4'd0;
      dout  <= 12'd0;
      done  <= 1'b0;
    end else if (fall_tick) begin
      done <= 1'b0;
      if (cs) begin
        rcnt <= 4'd0;
      end else begin
        shreg <= {mosi, shreg[11:1]};
        if (rcnt == 4'd11) begin
          dout <= {mosi, shreg[11:1]};
          done <= 1'b1;
          rcnt <= 4'd0;
        end else begin
          rcnt <= rcnt + 4'd1;
        end
      end
    end else if (cs) begin
      rcnt <= 4'd0;
    end
  end

endmodule

// ---------------------------------------------------------------------------
// spi_design: top-level loopback.
// ---------------------------------------------------------------------------
module spi_design #(
  parameter int DIV = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        newd,
  input  logic [11:0] din,
  output logic [11:0] dout,
  output logic        done
);

  logic cs;
  logic mosi;
  logic fall_tick;

  spi_master #(.DIV(DIV)) s1 (
    .clk       (clk),
    .rst       (rst),
    .newd      (newd),
    .din       (din),
    .cs        (cs),
    .mosi      (mosi),
    .fall_tick (fall_tick)
  );

  spi_slave s2 (
    .clk       (clk),
    .rst       (rst),
    .fall_tick (fall_tick),
    .cs        (cs),
    .mosi      (mosi),
    .dout      (dout),
    .done      (done)
  );

endmodule

// File: tb/tb_spi_design.sv
// Directed bench for spi_design (DIV = 10): reset, single/corner/back-to-back
// transfers, busy request handling, continuous requests and mid-transfer reset.
module tb_spi_design;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        newd = 1'b0;
  logic [11:0] din = 12'd0;
  logic [11:0] dout;
  logic        done;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_design #(.DIV(10)) dut (
    .clk  (clk),
    .rst  (rst),
    .newd (newd),
    .din  (din),
    .dout (dout),
    .done (done)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];
  int          done_cnt = 0;
  int          hi_cnt = 0;
  logic        done_q = 1'b0;

  // On each done rise compare dout with the oldest expected word; on each
  // done fall check the pulse lasted one sclk period (20 clk).
  always @(negedge clk) begin
    if (rst) begin
      if (done && !done_q) begin
        done_cnt++;
        hi_cnt = 1;
        if (exp_q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
        else chk("dout", {20'd0, dout}, {20'd0, exp_q.pop_front()});
      end else if (done) begin
        hi_cnt++;
      end
      if (!done && done_q) chk("done_width", hi_cnt, 32'd20);
      done_q = done;
    end else begin
      done_q = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_sclk(input logic lvl, output int n);
    n = 0;
    while (dut.s1.sclk !== lvl && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("timeout_sclk", 32'd0, 32'd1);
  endtask

  task automatic wait_rise();
    int n;
    wait_sclk(1'b0, n);
    wait_sclk(1'b1, n);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (dut.s1.cs !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("timeout_idle", 32'd0, 32'd1);
  endtask

  // Start one transfer; t_acc is the cycle stamp of the accepting sclk rise.
  task automatic send_word(input logic [11:0] d, output int t_acc);
    wait_idle();
    din  = d;
    newd = 1'b1;
    wait_rise();
    t_acc = cyc;
    newd = 1'b0;
    exp_q.push_back(d);
  endtask

  task automatic wait_done(output int t);
    int   n;
    logic prev;
    n    = 0;
    prev = done;
    t    = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (done && !prev) begin
        t = cyc;
        break;
      end
      prev = done;
    end
    if (n >= 400) chk("timeout_done", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [11:0] corner [3] = '{12'h000, 12'hFFF, 12'h001};

  initial begin
    int t_acc, t_done, t1, d1, d2, n, base;
    logic [11:0] w;

    // Reset
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_dout", {20'd0, dout}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sclk", {31'd0, dut.s1.sclk}, 32'd0);
    chk("rst_cs",   {31'd0, dut.s1.cs}, 32'd1);
    rst = 1'b1;
    wait_sclk(1'b1, n);
    chk("sclk_first_toggle", n, 32'd10);
    wait_sclk(1'b0, n);
    chk("sclk_period_half", n, 32'd10);

    // Single transfer with latency check
    send_word(12'hA5C, t_acc);
    wait_done(t_done);
    chk("latency", t_done - t_acc, 32'd230);

    // Corner data
    for (int i = 0; i < 3; i++) begin
      send_word(corner[i], t_acc);
      wait_done(t_done);
      chk("corner_latency", t_done - t_acc, 32'd230);
    end

    // Back-to-back random words
    base = done_cnt;
    for (int i = 0; i < 5; i++) begin
      w = 12'($urandom_range(0, 4095));
      send_word(w, t_acc);
      wait_done(t_done);
    end
    chk("b2b_done_count", done_cnt - base, 32'd5);

    // Busy: new din/newd mid-transfer must not disturb the word in flight
    send_word(12'h5A5, t_acc);
    repeat (3) wait_rise();
    din  = 12'h111;
    newd = 1'b1;
    repeat (2) wait_rise();
    newd = 1'b0;
    din  = 12'h000;
    base = done_cnt;
    wait_done(t_done);
    repeat (80) @(negedge clk);
    chk("busy_no_restart", done_cnt - base, 32'd1);
    chk("busy_idle_cs", {31'd0, dut.s1.cs}, 32'd1);

    // Continuous request: transfers repeat every 13 sclk periods
    wait_idle();
    din  = 12'h2B7;
    newd = 1'b1;
    wait_rise();
    t1 = cyc;
    exp_q.push_back(12'h2B7);
    exp_q.push_back(12'h2B7);
    wait_done(d1);
    wait_done(d2);
    newd = 1'b0;
    chk("cont_latency", d1 - t1, 32'd230);
    chk("cont_spacing", d2 - d1, 32'd260);

    // Mid-transfer reset
    wait_idle();
    repeat (40) @(negedge clk);
    send_word(12'hABC, t_acc);
    repeat (6) wait_rise();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    base = done_cnt;
    chk("midrst_dout", {20'd0, dout}, 32'd0);
    chk("midrst_cs",   {31'd0, dut.s1.cs}, 32'd1);
    chk("midrst_done", {31'd0, done}, 32'd0);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    chk("midrst_no_done", done_cnt - base, 32'd0);
    send_word(12'h3C3, t_acc);
    wait_done(t_done);
    chk("post_rst_latency", t_done - t_acc, 32'd230);
    repeat (40) @(negedge clk);
    chk("post_rst_done_count", done_cnt - base, 32'd1);
    chk("exp_q_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Absolute time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
